// File: rtl/wb_pkg.sv
// Shared definitions for the write-back commit stage: load-type encoding and
// default widths used by the commit stage and its load aligner.
package wb_pkg;

    localparam int WB_WIDTH_DEF      = 32;
    localparam int WB_REG_NUM_DEF    = 5;
    localparam int WB_STARVE_MAX_DEF = 4;

    // Codes 5..7 are undefined and are treated as a full-word load.
    typedef enum logic [2:0] {
        LDT_LW  = 3'd0,
        LDT_LH  = 3'd1,
        LDT_LHU = 3'd2,
        LDT_LB  = 3'd3,
        LDT_LBU = 3'd4
    } ldtype_e;

endpackage : wb_pkg

// File: rtl/load_align.sv
// Little-endian load alignment: picks the addressed byte/half of a raw memory
// word and sign- or zero-extends it to the full register width.
module load_align
    import wb_pkg::*;
#(
    parameter int WIDTH = WB_WIDTH_DEF
) (
    input  logic [2:0]       ldtype_i,
    input  logic [1:0]       addr_lo_i,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] aligned_o
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = addr_lo_i[1] ? raw_i[16 +: 16] : raw_i[0 +: 16];
        byte_sel = raw_i[{3'd0, addr_lo_i} * 5'd8 +: 8];
    end

    // Misaligned halves are not trapped here; the exception unit filters them.
    always_comb begin
        case (ldtype_i)
            LDT_LH:  aligned_o = {{(WIDTH-16){half_sel[15]}}, half_sel};
            LDT_LHU: aligned_o = {{(WIDTH-16){1'b0}}, half_sel};
            LDT_LB:  aligned_o = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            LDT_LBU: aligned_o = {{(WIDTH-8){1'b0}}, byte_sel};
            default: aligned_o = raw_i;
        endcase
    end

endmodule : load_align

// File: rtl/wb_commit.sv
// Write-back commit stage: MEM/WB register plus arbitration of the single
// regfile write port between in-order results and late load returns.
module wb_commit
    import wb_pkg::*;
#(
    parameter int WIDTH      = WB_WIDTH_DEF,
    parameter int REG_NUM    = WB_REG_NUM_DEF,
    parameter int STARVE_MAX = WB_STARVE_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_valid,
    output logic               mem_ready,
    input  logic               mem_regwrite,
    input  logic               mem_memtoreg,
    input  logic [2:0]         mem_ldtype,
    input  logic [1:0]         mem_addr_lo,
    input  logic [REG_NUM-1:0] mem_wa,
    input  logic [WIDTH-1:0]   mem_aluout,
    input  logic [WIDTH-1:0]   mem_rdata,
    input  logic               lr_valid,
    output logic               lr_ready,
    input  logic [2:0]         lr_ldtype,
    input  logic [1:0]         lr_addr_lo,
    input  logic [REG_NUM-1:0] lr_wa,
    input  logic [WIDTH-1:0]   lr_rdata,
    input  logic               flush,
    output logic               regwrite,
    output logic [REG_NUM-1:0] wa,
    output logic [WIDTH-1:0]   wd
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic               wb_valid_q,    wb_valid_d;
    logic               wb_regwrite_q, wb_regwrite_d;
    logic [REG_NUM-1:0] wb_wa_q,       wb_wa_d;
    logic [WIDTH-1:0]   wb_result_q,   wb_result_d;
    logic [CNT_W-1:0]   starve_cnt_q,  starve_cnt_d;

    logic [WIDTH-1:0]   mem_aligned;
    logic [WIDTH-1:0]   lr_aligned;
    logic               wb_live;

    load_align #(.WIDTH(WIDTH)) u_align_mem (
        .ldtype_i  (mem_ldtype),
        .addr_lo_i (mem_addr_lo),
        .raw_i     (mem_rdata),
        .aligned_o (mem_aligned)
    );

    load_align #(.WIDTH(WIDTH)) u_align_lr (
        .ldtype_i  (lr_ldtype),
        .addr_lo_i (lr_addr_lo),
        .raw_i     (lr_rdata),
        .aligned_o (lr_aligned)
    );

    assign mem_ready = (starve_cnt_q != CNT_MAX);
    assign wb_live   = wb_valid_q & wb_regwrite_q & (wb_wa_q != '0);

    // Result is resolved at capture so WB holds a single ready-to-write word.
    always_comb begin
        wb_valid_d    = 1'b0;
        wb_regwrite_d = wb_regwrite_q;
        wb_wa_d       = wb_wa_q;
        wb_result_d   = wb_result_q;
        if (mem_ready) begin
            wb_valid_d    = mem_valid & ~flush;
            wb_regwrite_d = mem_regwrite;
            wb_wa_d       = mem_wa;
            wb_result_d   = mem_memtoreg ? mem_aligned : mem_aluout;
        end
    end

    // A late return is granted only when the pipeline does not need the port;
    // rst_n gates the grant so the port stays quiet while in reset.
    always_comb begin
        regwrite = 1'b0;
        wa       = '0;
        wd       = '0;
        lr_ready = 1'b0;
        if (wb_live) begin
            regwrite = 1'b1;
            wa       = wb_wa_q;
            wd       = wb_result_q;
        end else if (lr_valid && rst_n) begin
            lr_ready = 1'b1;
            regwrite = (lr_wa != '0);
            wa       = lr_wa;
            wd       = lr_aligned;
        end
    end

    always_comb begin
        starve_cnt_d = '0;
        if (lr_valid && !lr_ready) begin
            starve_cnt_d = (starve_cnt_q == CNT_MAX) ? starve_cnt_q : starve_cnt_q + 1'b1;
        end
    end

    // NOTE: the payload is reset as well as the valid bit so wa/wd never carry
    // stale or unknown data, even though wb_valid alone gates the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_wa_q       <= '0;
            wb_result_q   <= '0;
            starve_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            wb_valid_q    <= wb_valid_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_wa_q       <= wb_wa_d;
            wb_result_q   <= wb_result_d;
            starve_cnt_q  <= starve_cnt_d;
        end
    end

endmodule : wb_commit

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: directed literal cases plus randomized
// traffic compared every cycle against a behavioural model.
module tb_wb_commit;

    localparam int WIDTH      = 32;
    localparam int REG_NUM    = 5;
    localparam int STARVE_MAX = 4;

    logic               clk;
    logic               rst_n;
    logic               mem_valid;
    logic               mem_ready;
    logic               mem_regwrite;
    logic               mem_memtoreg;
    logic [2:0]         mem_ldtype;
    logic [1:0]         mem_addr_lo;
    logic [REG_NUM-1:0] mem_wa;
    logic [WIDTH-1:0]   mem_aluout;
    logic [WIDTH-1:0]   mem_rdata;
    logic               lr_valid;
    logic               lr_ready;
    logic [2:0]         lr_ldtype;
    logic [1:0]         lr_addr_lo;
    logic [REG_NUM-1:0] lr_wa;
    logic [WIDTH-1:0]   lr_rdata;
    logic               flush;
    logic               regwrite;
    logic [REG_NUM-1:0] wa;
    logic [WIDTH-1:0]   wd;

    int n_tests = 0;
    int n_fail  = 0;

    wb_commit #(.WIDTH(WIDTH), .REG_NUM(REG_NUM), .STARVE_MAX(STARVE_MAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_regwrite (mem_regwrite),
        .mem_memtoreg (mem_memtoreg),
        .mem_ldtype   (mem_ldtype),
        .mem_addr_lo  (mem_addr_lo),
        .mem_wa       (mem_wa),
        .mem_aluout   (mem_aluout),
        .mem_rdata    (mem_rdata),
        .lr_valid     (lr_valid),
        .lr_ready     (lr_ready),
        .lr_ldtype    (lr_ldtype),
        .lr_addr_lo   (lr_addr_lo),
        .lr_wa        (lr_wa),
        .lr_rdata     (lr_rdata),
        .flush        (flush),
        .regwrite     (regwrite),
        .wa           (wa),
        .wd           (wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference alignment written as shift-and-mask arithmetic.
    function automatic logic [31:0] ref_align(input int unsigned t, input int unsigned a,
                                              input logic [31:0] raw);
        int unsigned v;
        case (t)
            1, 2: begin
                v = (raw >> ((a >= 2) ? 16 : 0)) & 32'h0000_FFFF;
                if (t == 1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            3, 4: begin
                v = (raw >> (8 * (a % 4))) & 32'h0000_00FF;
                if (t == 3 && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            default: v = raw;
        endcase
        return v;
    endfunction

    // Model state: the instruction sitting in WB and the refusal streak length.
    bit          m_valid;
    bit          m_rw;
    int unsigned m_wa;
    logic [31:0] m_res;
    int          m_cnt;

    function automatic bit model_live();
        return m_valid && m_rw && (m_wa != 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0;
            m_rw    = 0;
            m_wa    = 0;
            m_res   = '0;
            m_cnt   = 0;
        end else begin
            bit granted;
            bit accept;
            granted = !model_live() && lr_valid;
            accept  = (m_cnt != STARVE_MAX);
            if (lr_valid && !granted) m_cnt = (m_cnt < STARVE_MAX) ? m_cnt + 1 : STARVE_MAX;
            else                      m_cnt = 0;
            if (accept) begin
                m_valid = mem_valid && !flush;
                m_rw    = mem_regwrite;
                m_wa    = mem_wa;
                m_res   = mem_memtoreg ? ref_align(mem_ldtype, mem_addr_lo, mem_rdata) : mem_aluout;
            end else begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        bit          e_rw;
        bit          e_lr;
        bit          e_mr;
        int unsigned e_wa;
        logic [31:0] e_wd;
        e_rw = 0; e_lr = 0; e_wa = 0; e_wd = '0;
        e_mr = (m_cnt != STARVE_MAX);
        if (rst_n) begin
            if (model_live()) begin
                e_rw = 1; e_wa = m_wa; e_wd = m_res;
            end else if (lr_valid) begin
                e_lr = 1; e_rw = (lr_wa != 0); e_wa = lr_wa;
                e_wd = ref_align(lr_ldtype, lr_addr_lo, lr_rdata);
            end
        end
        check("cmp_regwrite",  32'(regwrite),  32'(e_rw));
        check("cmp_wa",        32'(wa),        e_wa);
        check("cmp_wd",        wd,             e_wd);
        check("cmp_lr_ready",  32'(lr_ready),  32'(e_lr));
        check("cmp_mem_ready", 32'(mem_ready), 32'(e_mr));
    end

    task automatic mem_set(input bit v, input bit rw, input bit m2r, input logic [2:0] ldt,
                           input logic [1:0] a, input logic [4:0] dst,
                           input logic [31:0] alu, input logic [31:0] rd);
        mem_valid = v; mem_regwrite = rw; mem_memtoreg = m2r; mem_ldtype = ldt;
        mem_addr_lo = a; mem_wa = dst; mem_aluout = alu; mem_rdata = rd;
    endtask

    // Drive one entry, let it be captured, then idle the MEM inputs.
    task automatic mem_push(input bit rw, input bit m2r, input logic [2:0] ldt,
                            input logic [1:0] a, input logic [4:0] dst,
                            input logic [31:0] alu, input logic [31:0] rd);
        @(posedge clk); #1;
        mem_set(1'b1, rw, m2r, ldt, a, dst, alu, rd);
        @(posedge clk); #1;
        mem_valid = 1'b0;
    endtask

    logic [2:0]  ld_t   [4] = '{3'd3, 3'd4, 3'd1, 3'd2};
    logic [1:0]  ld_a   [4] = '{2'd0, 2'd1, 2'd2, 2'd2};
    logic [31:0] ld_exp [4] = '{32'hFFFF_FF81, 32'h0000_007F, 32'hFFFF_80F0, 32'h0000_80F0};
    bit          st_lr  [7] = '{0, 0, 0, 0, 0, 1, 1};
    bit          st_mr  [7] = '{1, 1, 1, 1, 0, 0, 1};

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        mem_set(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, '0, '0);
        lr_valid = 1'b1; lr_ldtype = 3'd0; lr_addr_lo = 2'd0; lr_wa = 5'd7; lr_rdata = 32'h1111_2222;

        // Reset state, with a late return pending that must not be granted.
        #12;
        check("rst_regwrite",  32'(regwrite),  32'd0);
        check("rst_wa",        32'(wa),        32'd0);
        check("rst_wd",        wd,             32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd1);
        check("rst_lr_ready",  32'(lr_ready),  32'd0);
        lr_valid = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;

        // ALU result appears on the write port the cycle after capture.
        mem_push(1'b1, 1'b0, 3'd0, 2'd0, 5'd5, 32'h1234_5678, 32'hDEAD_BEEF);
        check("alu_regwrite", 32'(regwrite), 32'd1);
        check("alu_wa",       32'(wa),       32'd5);
        check("alu_wd",       wd,            32'h1234_5678);

        for (int i = 0; i < 4; i++) begin
            check("model_align", ref_align(ld_t[i], ld_a[i], 32'h80F0_7F81), ld_exp[i]);
            mem_push(1'b1, 1'b1, ld_t[i], ld_a[i], 5'd6, 32'h0, 32'h80F0_7F81);
            check("load_wd", wd, ld_exp[i]);
        end

        // r0 destination never writes; the idle port goes to the late return.
        mem_push(1'b1, 1'b0, 3'd0, 2'd0, 5'd0, 32'hFFFF_FFFF, 32'h0);
        check("r0_regwrite", 32'(regwrite), 32'd0);
        lr_valid = 1'b1; lr_wa = 5'd7; lr_ldtype = 3'd0; lr_rdata = 32'hCAFE_F00D;
        #1;
        check("lr_ready",    32'(lr_ready), 32'd1);
        check("lr_regwrite", 32'(regwrite), 32'd1);
        check("lr_wa",       32'(wa),       32'd7);
        check("lr_wd",       wd,            32'hCAFE_F00D);

        // Keep WB busy every cycle while a late return waits.
        @(posedge clk); #1;
        mem_set(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd10, 32'hA5A5_0000, 32'h0);
        lr_wa = 5'd11;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #2;
            check("starve_lr_ready",  32'(lr_ready),  32'(st_lr[i]));
            check("starve_mem_ready", 32'(mem_ready), 32'(st_mr[i]));
        end
        lr_valid = 1'b0;
        mem_valid = 1'b0;

        // A flushed capture is dropped; the entry already in WB still commits.
        @(posedge clk); #1;
        mem_set(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd3, 32'h0000_0033, 32'h0);
        @(posedge clk); #1;
        mem_set(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd9, 32'h0000_0099, 32'h0);
        flush = 1'b1;
        check("flush_prev_regwrite", 32'(regwrite), 32'd1);
        check("flush_prev_wa",       32'(wa),       32'd3);
        check("flush_prev_wd",       wd,            32'h0000_0033);
        @(posedge clk); #1;
        mem_valid = 1'b0; flush = 1'b0;
        check("flush_killed", 32'(regwrite), 32'd0);

        // Asynchronous reset drops a live WB entry immediately.
        mem_push(1'b1, 1'b0, 3'd0, 2'd0, 5'd12, 32'h0BAD_0BAD, 32'h0);
        check("pre_rst_regwrite", 32'(regwrite), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_regwrite", 32'(regwrite), 32'd0);
        check("async_rst_wd",       wd,            32'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_regwrite", 32'(regwrite), 32'd0);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            mem_set(($urandom % 8) != 0, ($urandom % 6) != 0, $urandom % 2,
                    3'($urandom_range(0, 7)), 2'($urandom), 5'($urandom_range(0, 31)),
                    $urandom, $urandom);
            flush      = ($urandom % 8) == 0;
            lr_valid   = ($urandom % 3) != 0;
            lr_ldtype  = 3'($urandom_range(0, 7));
            lr_addr_lo = 2'($urandom);
            lr_wa      = 5'($urandom_range(0, 31));
            lr_rdata   = $urandom;
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                @(negedge clk); #1 rst_n = 1'b1;
            end
        end
        @(posedge clk); #1;
        mem_valid = 1'b0; lr_valid = 1'b0; flush = 1'b0;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_wb_commit
